if_prefetch_stage: RTL

- Instruction-fetch front end that produces the `Ins`/`PC` stream consumed by the decode stage.
- Issues word fetches to instruction memory through a req/ack handshake and buffers the returned words in a small prefetch FIFO.
- Presents the FIFO head to decode and pops it when decode is not frozen.
- Redirects and flushes on a taken branch, including squashing a fetch that is already in flight.

---
 rtl/if_prefetch_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//   Instruction-fetch front end. Fetches words from instruction memory over a
//   req/ack handshake, buffers them in a DEPTH-entry prefetch FIFO and presents
//   the FIFO head (Ins, PC = head address + 4) to decode. A taken branch
//   flushes the FIFO and redirects fetch. A request that is still waiting for
//   its ack is squashed via the DROP state, which keeps imem_addr stable.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   freeze             decode stall, holds the FIFO head
//   Branch_taken       redirect request, highest priority
//   Branch_Address     redirect target (low two bits ignored)
//   imem_req/addr      fetch request / word address
//   imem_ack/rdata     memory accept, data valid in the ack cycle
//   Ins, PC, Ins_valid FIFO head towards decode (zero when empty)
//   bubble_cnt         saturating count of empty, unfrozen decode cycles
//                      (present only when BUBBLE_CNT_EN is defined)
//
// Optional feature macro: BUBBLE_CNT_EN
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_Address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Ins,
  output logic [31:0] PC,
  output logic        Ins_valid
`ifdef BUBBLE_CNT_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     fifo_addr_q [DEPTH];
  logic [31:0]     fifo_ins_q  [DEPTH];

  logic            req_core_s;
  logic            push_s;
  logic            pop_s;
  logic [31:0]     target_s;

  // In DROP the squashed request stays up until its ack; in FETCH we only
  // request when there is guaranteed room, so a push can never overflow.
  assign req_core_s = (state_q == ST_DROP) || (count_q < DEPTH_C);
  assign imem_req   = req_core_s && !rst;
  assign imem_addr  = fetch_pc_q;

  assign target_s = Branch_Address & 32'hFFFF_FFFC;
  assign push_s   = (state_q == ST_FETCH) && req_core_s && imem_ack && !Branch_taken;
  assign pop_s    = (count_q != {CW{1'b0}}) && !freeze && !Branch_taken;

  assign Ins_valid = (count_q != {CW{1'b0}});
  assign Ins       = Ins_valid ? fifo_ins_q[rd_ptr_q] : 32'h0000_0000;
  assign PC        = Ins_valid ? (fifo_addr_q[rd_ptr_q] + 32'd4) : 32'h0000_0000;

  // Next-state logic for the fetch FSM, fetch address and FIFO pointers.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (Branch_taken) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
      if (state_q == ST_FETCH) begin
        // A waiting request must complete before the new address may appear.
        if (req_core_s && !imem_ack) begin
          state_d       = ST_DROP;
          redirect_pc_d = target_s;
        end else begin
          fetch_pc_d = target_s;
        end
      end else begin
        // Already squashing: the newest target wins.
        if (imem_ack) begin
          state_d    = ST_FETCH;
          fetch_pc_d = target_s;
        end else begin
          redirect_pc_d = target_s;
        end
      end
    end else begin
      if ((state_q == ST_DROP) && imem_ack) begin
        state_d    = ST_FETCH;
        fetch_pc_d = redirect_pc_q;
      end else if (push_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // State, address and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      rd_ptr_q      <= {AW{1'b0}};
      wr_ptr_q      <= {AW{1'b0}};
      count_q       <= {CW{1'b0}};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage: each entry holds the fetch address and the fetched word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_addr_q[i] <= 32'h0000_0000;
        fifo_ins_q[i]  <= 32'h0000_0000;
      end
    end else if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= fetch_pc_q;
      fifo_ins_q[wr_ptr_q]  <= imem_rdata;
    end else begin
      fifo_addr_q[wr_ptr_q] <= fifo_addr_q[wr_ptr_q];
      fifo_ins_q[wr_ptr_q]  <= fifo_ins_q[wr_ptr_q];
    end
  end

`ifdef BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q;

  // Saturating count of cycles where decode is ready but has nothing to take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 16'h0000;
    end else if (!freeze && !Ins_valid && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'h0001;
    end else begin
      bubble_cnt_q <= bubble_cnt_q;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
